// File: rtl/soc_spi_pkg.sv
// Shared types and defaults for the SoC SPI master.
package soc_spi_pkg;

    localparam int unsigned SPI_DATA_W = 8;
    localparam int unsigned SPI_DIV_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } spi_state_e;

    typedef struct packed {
        logic [SPI_DIV_W-1:0] div;
        logic                 cpol;
        logic                 cpha;
        logic                 burst;
    } spi_cfg_t;

endpackage

// File: rtl/soc_spi_bus.sv
// SoC SPI pin bundle; ss is active-low.
interface soc_spi_bus;
    logic ss;
    logic sck;
    logic mosi;
    logic miso;

    modport master (output ss, output sck, output mosi, input miso);
    modport slave  (input ss, input sck, input mosi, output miso);
endinterface

// File: rtl/soc_spi_clk_gen.sv
// Half-period counter: counts 0..i_div, flags the terminal count, clears on demand.
module soc_spi_clk_gen #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick_c
);
    logic [DIV_WIDTH-1:0] r_cnt;

    assign o_tick_c = (r_cnt == i_div);

    // Counter never exceeds i_div, so the full DIV_WIDTH range is safe.
    always_ff @(posedge clk) begin
        if (rst || i_clear || o_tick_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
        end
    end
endmodule

// File: rtl/soc_spi_master.sv
// Byte-oriented SPI master with programmable divider, CPOL/CPHA and burst framing.
module soc_spi_master
    import soc_spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SPI_DATA_W,
    parameter int unsigned DIV_WIDTH  = SPI_DIV_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
    input  logic                  cfg_cpol,
    input  logic                  cfg_cpha,
    input  logic                  cfg_burst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    soc_spi_bus.master            spi
);
    localparam int unsigned EDGE_W    = $clog2(2 * DATA_WIDTH);
    localparam int unsigned LAST_EDGE = 2 * DATA_WIDTH - 1;

    spi_state_e            r_state;
    spi_state_e            w_state_nxt;
    logic [DIV_WIDTH-1:0]  r_div;
    logic                  r_cpol;
    logic                  r_cpha;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [EDGE_W-1:0]     r_edge;
    logic                  r_ss;
    logic                  r_sck;
    logic                  r_mosi;
    logic                  r_rx_valid;

    logic                  w_tick;
    logic                  w_clear;
    logic                  w_last_tick;
    logic                  w_lead;
    logic                  w_sample;
    logic                  w_tx_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_rx_nxt;

    soc_spi_clk_gen #(.DIV_WIDTH(DIV_WIDTH)) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_div    (r_div),
        .o_tick_c (w_tick)
    );

    // Tick r_edge counts from 0, so even counts are the odd (leading) edges.
    assign w_clear     = (w_state_nxt != r_state);
    assign w_last_tick = (r_state == XFER) && w_tick && (r_edge == EDGE_W'(LAST_EDGE));
    assign w_lead      = ~r_edge[0];
    assign w_sample    = (r_state == XFER) && w_tick && (r_cpha ? ~w_lead : w_lead);
    assign w_rx_nxt    = w_sample ? {r_rx[DATA_WIDTH-2:0], spi.miso} : r_rx;
    assign w_tx_ready  = (r_state == IDLE) || (w_last_tick && cfg_burst);
    assign w_accept    = tx_valid && w_tx_ready;

    assign tx_ready = w_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = (r_state != IDLE);
    assign spi.ss   = r_ss;
    assign spi.sck  = r_sck;
    assign spi.mosi = r_mosi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = LEAD;
            LEAD:    if (w_tick) w_state_nxt = XFER;
            XFER:    if (w_last_tick && !w_accept) w_state_nxt = TRAIL;
            TRAIL:   if (w_tick) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shift engine, pin drivers and latched configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_edge     <= '0;
            r_ss       <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx       <= w_rx_nxt;
            case (r_state)
                IDLE: begin
                    r_sck <= cfg_cpol;
                    if (w_accept) begin
                        r_div  <= cfg_div;
                        r_cpol <= cfg_cpol;
                        r_cpha <= cfg_cpha;
                        r_tx   <= tx_data;
                        r_ss   <= 1'b0;
                        r_mosi <= tx_data[DATA_WIDTH-1];
                        r_edge <= '0;
                    end
                end
                LEAD: begin
                    r_sck <= r_cpol;
                end
                XFER: begin
                    if (w_tick) begin
                        r_sck  <= ~r_sck;
                        r_edge <= w_last_tick ? '0 : r_edge + EDGE_W'(1);
                        if (r_cpha && w_lead) begin
                            r_mosi <= r_tx[DATA_WIDTH-1];
                            r_tx   <= r_tx << 1;
                        end
                        if (!r_cpha && !w_lead && !w_last_tick) begin
                            r_mosi <= r_tx[DATA_WIDTH-2];
                            r_tx   <= r_tx << 1;
                        end
                    end
                    // Word boundary: publish rx and, in burst, chain the next word.
                    if (w_last_tick) begin
                        r_rx_data  <= w_rx_nxt;
                        r_rx_valid <= 1'b1;
                        if (w_accept) begin
                            r_tx   <= tx_data;
                            r_mosi <= tx_data[DATA_WIDTH-1];
                        end
                    end
                end
                TRAIL: begin
                    r_sck <= r_cpol;
                    if (w_tick) r_ss <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_spi_master.sv
// Scoreboard bench for soc_spi_master: protocol-level slave model, frame timing and rx checks.
module tb_soc_spi_master;
    localparam int unsigned DW  = 8;
    localparam int unsigned DVW = 8;

    typedef struct {
        int   len;
        int   edges;
        int   h;
        logic cpol;
    } frame_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [DVW-1:0] cfg_div;
    logic           cfg_cpol, cfg_cpha, cfg_burst;
    logic [DW-1:0]  tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [DW-1:0]  rx_data;
    logic           rx_valid;
    logic           busy;
    logic           s_miso = 1'b0;
    bit             loopback = 0;

    soc_spi_bus spi_if ();
    assign spi_if.miso = loopback ? spi_if.mosi : s_miso;

    soc_spi_master #(.DATA_WIDTH(DW), .DIV_WIDTH(DVW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_div   (cfg_div),
        .cfg_cpol  (cfg_cpol),
        .cfg_cpha  (cfg_cpha),
        .cfg_burst (cfg_burst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .spi       (spi_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] rxq[$];
    logic [DW-1:0] mosiq[$];
    logic [DW-1:0] slaveq[$];
    frame_t        fq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Expected frame: LEAD + 2*DW half-periods per word + TRAIL, all H = div+1 cycles.
    task automatic expect_frame(input int words, input int div, input logic cpol);
        frame_t f;
        f.h     = div + 1;
        f.edges = 2 * DW * words;
        f.len   = (2 * DW * words + 2) * f.h;
        f.cpol  = cpol;
        fq.push_back(f);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] sw, input bit hold);
        int n;
        tx_data  = d;
        tx_valid = 1'b1;
        slaveq.push_back(sw);
        mosiq.push_back(d);
        rxq.push_back(loopback ? d : sw);
        n = 0;
        while (!tx_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            fail_now("send_timeout");
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || rxq.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) fail_now("idle_timeout");
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_edges(input int k);
        int   cnt;
        int   n;
        logic prev;
        cnt  = 0;
        n    = 0;
        prev = spi_if.sck;
        while (cnt < k && n < 20000) begin
            @(posedge clk);
            #1;
            if (!spi_if.ss && spi_if.sck !== prev) cnt++;
            prev = spi_if.sck;
            n++;
        end
        if (cnt < k) fail_now("edge_wait_timeout");
    endtask

    // Slave: presents its word and captures mosi purely from observed sck edges.
    logic          s_prev_ss = 1'b1, s_prev_sck = 1'b0, s_prev_mosi = 1'b0;
    logic          s_cpha = 1'b0;
    logic [DW-1:0] s_word = '0, s_cap = '0;
    int            s_edge = 0;
    bit            s_loaded = 0;

    task automatic slave_load();
        s_word   = slaveq.pop_front();
        s_miso   = s_word[DW-1];
        s_loaded = 1;
    endtask

    always begin
        bit lead;
        @(posedge clk);
        #1;
        if (rst) begin
            s_edge   = 0;
            s_loaded = 0;
        end else begin
            if (s_prev_ss && !spi_if.ss) begin
                s_cpha = cfg_cpha;
                s_edge = 0;
                s_cap  = '0;
                if (!s_loaded) begin
                    if (slaveq.size() == 0) fail_now("slave_no_word");
                    else slave_load();
                end
            end else if (!s_prev_ss && !spi_if.ss && spi_if.sck !== s_prev_sck) begin
                s_edge++;
                lead = (s_edge % 2) == 1;
                if (s_cpha ? !lead : lead) s_cap = {s_cap[DW-2:0], s_prev_mosi};
                if (s_cpha && lead) begin
                    s_miso = s_word[DW-1];
                    s_word = s_word << 1;
                end
                if (!s_cpha && !lead && s_edge != 2 * DW) begin
                    s_word = s_word << 1;
                    s_miso = s_word[DW-1];
                end
                if (s_edge == 2 * DW) begin
                    if (mosiq.size() == 0) fail_now("mosi_unexpected_word");
                    else chk("mosi_word", s_cap, mosiq.pop_front());
                    s_edge   = 0;
                    s_cap    = '0;
                    s_loaded = 0;
                    if (slaveq.size() != 0) slave_load();
                end
            end
        end
        s_prev_ss   = spi_if.ss;
        s_prev_sck  = spi_if.sck;
        s_prev_mosi = spi_if.mosi;
    end

    // Frame monitor: ss-low length, edge count, lead delay, half-period, idle level.
    bit     f_in = 0;
    int     f_len = 0, f_edges = 0, f_since = 0;
    logic   f_prev_sck = 1'b0;
    frame_t f_cur;

    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            f_in = 0;
        end else if (!f_in) begin
            if (!spi_if.ss) begin
                f_in    = 1;
                f_len   = 1;
                f_edges = 0;
                f_since = 0;
                if (fq.size() == 0) begin
                    fail_now("frame_unexpected");
                    f_cur = '{len: 0, edges: 0, h: 1, cpol: 1'b0};
                end else begin
                    f_cur = fq.pop_front();
                    chk("sck_idle_at_ss_fall", spi_if.sck, f_cur.cpol);
                end
            end
        end else if (spi_if.ss) begin
            chk("ss_low_cycles", f_len, f_cur.len);
            chk("sck_edge_count", f_edges, f_cur.edges);
            f_in = 0;
        end else begin
            f_len++;
            f_since++;
            if (spi_if.sck !== f_prev_sck) begin
                f_edges++;
                if (f_edges == 1) chk("first_edge_delay", f_since, 2 * f_cur.h);
                else chk("half_period", f_since, f_cur.h);
                f_since = 0;
            end
        end
        f_prev_sck = spi_if.sck;
    end

    // Received-word monitor.
    always begin
        @(posedge clk);
        #1;
        if (!rst && rx_valid) begin
            if (rxq.size() == 0) fail_now("rx_valid_unexpected");
            else chk("rx_data", rx_data, rxq.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        cfg_div   = '0;
        cfg_cpol  = 1'b0;
        cfg_cpha  = 1'b0;
        cfg_burst = 1'b0;
        tx_data   = '0;
        tx_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss", spi_if.ss, 1'b1);
        chk("rst_sck", spi_if.sck, 1'b0);
        chk("rst_mosi", spi_if.mosi, 1'b0);
        chk("rst_rx_data", rx_data, '0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        chk("tx_ready_after_rst", tx_ready, 1'b1);

        // Mode 0, div 0, loopback
        loopback = 1;
        expect_frame(1, 0, 1'b0);
        send(8'hA5, 8'hA5, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_ready && n < 1000);
        chk("ready_latency", n, 19);
        wait_idle();
        loopback = 0;

        // Mode 3, div 3, slave returns 0x3C
        cfg_cpol = 1'b1;
        cfg_cpha = 1'b1;
        cfg_div  = 8'd3;
        repeat (2) @(negedge clk);
        chk("idle_sck_follows_cpol", spi_if.sck, 1'b1);
        expect_frame(1, 3, 1'b1);
        send(DW'($urandom), 8'h3C, 0);
        wait_idle();

        // Burst of three words
        cfg_cpol  = 1'b0;
        cfg_cpha  = 1'b0;
        cfg_div   = 8'd1;
        cfg_burst = 1'b1;
        expect_frame(3, 1, 1'b0);
        send(8'h01, DW'($urandom), 1);
        send(8'h02, DW'($urandom), 1);
        send(8'h03, DW'($urandom), 0);
        wait_idle();
        cfg_burst = 1'b0;

        // Config change mid-transfer
        cfg_div = 8'd1;
        expect_frame(1, 1, 1'b0);
        send(DW'($urandom), DW'($urandom), 0);
        wait_edges(5);
        cfg_div  = 8'd7;
        cfg_cpol = 1'b1;
        expect_frame(1, 7, 1'b1);
        send(DW'($urandom), DW'($urandom), 0);
        wait_idle();

        // Reset at edge 9
        @(negedge clk);
        cfg_div  = 8'd0;
        cfg_cpol = 1'b0;
        expect_frame(1, 0, 1'b0);
        send(DW'($urandom), DW'($urandom), 0);
        wait_edges(9);
        rst = 1'b1;
        void'(mosiq.pop_back());
        void'(rxq.pop_back());
        @(posedge clk);
        #1;
        chk("midrst_ss", spi_if.ss, 1'b1);
        chk("midrst_sck", spi_if.sck, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rx_valid", rx_valid, 1'b0);
        chk("midrst_tx_ready", tx_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Maximum divider
        cfg_div = 8'd255;
        expect_frame(1, 255, 1'b0);
        send(8'hFF, DW'($urandom), 0);
        wait_idle();

        // Randomized modes and data
        for (int i = 0; i < 6; i++) begin
            cfg_div  = DVW'($urandom_range(0, 3));
            cfg_cpol = 1'($urandom);
            cfg_cpha = 1'($urandom);
            expect_frame(1, int'(cfg_div), cfg_cpol);
            send(DW'($urandom), DW'($urandom), 0);
            wait_idle();
        end

        repeat (10) @(negedge clk);
        chk("rx_queue_drained", rxq.size(), 0);
        chk("mosi_queue_drained", mosiq.size(), 0);
        chk("frame_queue_drained", fq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
